// File: rtl/adc_scale_ramp_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_scale_ramp_ctrl_if                                                   |
// | Register-side bus of the ADC I/Q scale ramp sequencer.                   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface adc_scale_ramp_ctrl_if #(
   parameter int W = 16
);
   logic [31:0]  i_target_word;
   logic [31:0]  q_target_word;
   logic [31:0]  ctrl_word;
   logic [W-1:0] i_scale;
   logic [W-1:0] q_scale;
   logic         busy;
   logic         done;
   logic [31:0]  status_word;

   modport master (
      output i_target_word, q_target_word, ctrl_word,
      input  i_scale, q_scale, busy, done, status_word
   );

   modport slave (
      input  i_target_word, q_target_word, ctrl_word,
      output i_scale, q_scale, busy, done, status_word
   );
endinterface
`default_nettype wire

// File: rtl/adc_scale_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_scale_ramp_ctrl                                                      |
// | Ramps the ADC I/Q scale factors toward latched targets in bounded steps  |
// | with a programmable dwell. Optional macro ADC_SCALE_RAMP_CNT_EN adds an  |
// | 8-bit completed-ramp counter on status_word[31:24].                      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module adc_scale_ramp_ctrl #(
   parameter int          W           = 16,
   parameter logic [15:0] RESET_SCALE = 16'h4000
) (
   input  wire logic            user_clk,
   input  wire logic            user_rst_n,
   adc_scale_ramp_ctrl_if.slave bus
);

   // Wide enough to hold cur+step without wrap even when W < 8.
   localparam int WX = ((W > 8) ? W : 8) + 1;
   localparam logic [W-1:0] c_rst_scale = RESET_SCALE[W-1:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STEP  = 2'd1,
      S_DWELL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic          r_go_prev;
   logic [W-1:0]  r_i_scale;
   logic [W-1:0]  r_q_scale;
   logic [W-1:0]  r_i_tgt;
   logic [W-1:0]  r_q_tgt;
   logic [7:0]    r_step;
   logic [15:0]   r_dwell;
   logic [15:0]   r_dwell_cnt;
   logic          r_overrun;

   logic          w_go;
   logic          w_abort;
   logic          w_go_evt;
   logic          w_accept;
   logic          w_busy;
   logic          w_at_tgt;
   logic [W-1:0]  w_i_nxt;
   logic [W-1:0]  w_q_nxt;
   logic [7:0]    w_cnt;
   logic          w_unused_bits;

   assign w_go     = bus.ctrl_word[0];
   assign w_abort  = bus.ctrl_word[1];
   assign w_go_evt = w_go & ~r_go_prev;
   assign w_busy   = (r_state != S_IDLE);
   assign w_accept = w_go_evt & ~w_abort & ~w_busy;
   assign w_at_tgt = (r_i_scale == r_i_tgt) && (r_q_scale == r_q_tgt);

   assign w_unused_bits = ^{bus.i_target_word[31:W], bus.q_target_word[31:W],
                            bus.ctrl_word[7:2]};

   // One increment toward tgt, saturating at tgt; step of zero jumps.
   function automatic logic [W-1:0] f_step_toward(
      input logic [W-1:0] cur,
      input logic [W-1:0] tgt,
      input logic [7:0]   step
   );
      logic [WX-1:0] v_c;
      logic [WX-1:0] v_t;
      logic [WX-1:0] v_s;
      logic [W-1:0]  v_r;
      v_c = WX'(cur);
      v_t = WX'(tgt);
      v_s = WX'(step);
      v_r = cur;
      if (step == 8'd0) begin
         v_r = tgt;
      end else if (v_c < v_t) begin
         v_r = (v_s >= (v_t - v_c)) ? tgt : W'(v_c + v_s);
      end else if (v_c > v_t) begin
         v_r = (v_s >= (v_c - v_t)) ? tgt : W'(v_c - v_s);
      end
      return v_r;
   endfunction

   assign w_i_nxt = f_step_toward(r_i_scale, r_i_tgt, r_step);
   assign w_q_nxt = f_step_toward(r_q_scale, r_q_tgt, r_step);

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_STEP;
         end
         S_STEP: begin
            if ((w_i_nxt == r_i_tgt) && (w_q_nxt == r_q_tgt)) w_state_nxt = S_DONE;
            else                                              w_state_nxt = S_DWELL;
         end
         S_DWELL: begin
            if (r_dwell_cnt >= r_dwell) w_state_nxt = S_STEP;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (w_abort) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_go_prev   <= 1'b1;
         r_i_scale   <= c_rst_scale;
         r_q_scale   <= c_rst_scale;
         r_i_tgt     <= c_rst_scale;
         r_q_tgt     <= c_rst_scale;
         r_step      <= 8'd0;
         r_dwell     <= 16'd0;
         r_dwell_cnt <= 16'd0;
         r_overrun   <= 1'b0;
      end else begin
         r_go_prev <= w_go;
         if (w_accept) begin
            r_i_tgt   <= bus.i_target_word[W-1:0];
            r_q_tgt   <= bus.q_target_word[W-1:0];
            r_step    <= bus.ctrl_word[15:8];
            r_dwell   <= bus.ctrl_word[31:16];
            r_overrun <= 1'b0;
         end else if (w_go_evt && w_busy && !w_abort) begin
            r_overrun <= 1'b1;
         end
         if ((r_state == S_STEP) && !w_abort) begin
            r_i_scale <= w_i_nxt;
            r_q_scale <= w_q_nxt;
         end
         // Dwell counter starts at 1 so that dwell=0 still costs one cycle.
         if (r_state == S_STEP) begin
            r_dwell_cnt <= 16'd1;
         end else if (r_state == S_DWELL) begin
            r_dwell_cnt <= r_dwell_cnt + 16'd1;
         end
      end
   end

`ifdef ADC_SCALE_RAMP_CNT_EN
   logic [7:0] r_ramp_cnt;

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         r_ramp_cnt <= 8'd0;
      end else if (r_state == S_DONE) begin
         r_ramp_cnt <= r_ramp_cnt + 8'd1;
      end
   end

   assign w_cnt = r_ramp_cnt;
`else
   assign w_cnt = 8'd0;
`endif

   assign bus.i_scale     = r_i_scale;
   assign bus.q_scale     = r_q_scale;
   assign bus.busy        = w_busy;
   assign bus.done        = (r_state == S_DONE);
   assign bus.status_word = {w_cnt, 21'd0, w_at_tgt, r_overrun, w_busy};

endmodule
`default_nettype wire

// File: tb/tb_adc_scale_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adc_scale_ramp_ctrl                                                   |
// | Directed self-checking bench for the ADC I/Q scale ramp sequencer.       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_adc_scale_ramp_ctrl;

   logic user_clk;
   logic user_rst_n;
   int   n_chk;
   int   n_bad;
   int   n_ramps;
   int   n_done_seen;
   logic [7:0] r_exp_cnt;

   adc_scale_ramp_ctrl_if #(.W(16)) bus ();

   adc_scale_ramp_ctrl #(
      .W           (16),
      .RESET_SCALE (16'h4000)
   ) u_dut (
      .user_clk   (user_clk),
      .user_rst_n (user_rst_n),
      .bus        (bus)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge user_clk);
   endtask

   function automatic logic [31:0] mk_ctrl(input logic [15:0] dwell, input logic [7:0] step,
                                           input logic abort, input logic go);
      return {dwell, step, 6'd0, abort, go};
   endfunction

   function automatic logic [31:0] exp_status(input logic b, input logic ovr, input logic at);
      logic [7:0] cnt;
`ifdef ADC_SCALE_RAMP_CNT_EN
      cnt = r_exp_cnt;
`else
      cnt = 8'd0;
`endif
      return {cnt, 21'd0, at, ovr, b};
   endfunction

   task automatic set_tgt(input logic [15:0] ti, input logic [15:0] tq);
      bus.i_target_word = {16'hDEAD, ti};
      bus.q_target_word = {16'hBEEF, tq};
   endtask

   task automatic do_jump();
      bus.ctrl_word = mk_ctrl(16'd0, 8'd0, 1'b0, 1'b1);
      tick(1);
      bus.ctrl_word = 32'd0;
      tick(1);
      n_ramps++;
      r_exp_cnt++;
      tick(1);
   endtask

   initial begin
      n_chk = 0; n_bad = 0; n_ramps = 0; n_done_seen = 0; r_exp_cnt = 8'd0;
      user_rst_n = 1'b0;
      bus.ctrl_word = 32'd0;
      set_tgt(16'h0000, 16'h0000);
      tick(2);
      user_rst_n = 1'b1;
      tick(1);
      check("rst_i", bus.i_scale, 32'h4000);
      check("rst_q", bus.q_scale, 32'h4000);
      check("rst_busy", bus.busy, 32'd0);
      check("rst_done", bus.done, 32'd0);
      check("rst_status", bus.status_word, 32'h0000_0004);

      // go held high through reset must not start a ramp
      user_rst_n = 1'b0;
      bus.ctrl_word = mk_ctrl(16'd0, 8'd0, 1'b0, 1'b1);
      tick(2);
      user_rst_n = 1'b1;
      tick(3);
      check("rstgo_busy", bus.busy, 32'd0);
      check("rstgo_status", bus.status_word, 32'h0000_0004);
      bus.ctrl_word = 32'd0;
      tick(1);

      // stepped ramp, step 4, dwell 2
      set_tgt(16'h4010, 16'h3FF8);
      bus.ctrl_word = mk_ctrl(16'd2, 8'd4, 1'b0, 1'b1);
      tick(1);
      check("st_busy_rise", bus.busy, 32'd1);
      check("st_i0", bus.i_scale, 32'h4000);
      bus.ctrl_word = mk_ctrl(16'd2, 8'd4, 1'b0, 1'b0);
      tick(1);
      check("st_i1", bus.i_scale, 32'h4004);
      check("st_q1", bus.q_scale, 32'h3FFC);
      check("st_status1", bus.status_word, exp_status(1'b1, 1'b0, 1'b0));
      set_tgt(16'h1234, 16'h5678);
      tick(3);
      check("st_i2", bus.i_scale, 32'h4008);
      check("st_q2", bus.q_scale, 32'h3FF8);
      check("st_done2", bus.done, 32'd0);
      tick(3);
      check("st_i3", bus.i_scale, 32'h400C);
      check("st_q3", bus.q_scale, 32'h3FF8);
      tick(3);
      check("st_i4", bus.i_scale, 32'h4010);
      check("st_q4", bus.q_scale, 32'h3FF8);
      check("st_done", bus.done, 32'd1);
      check("st_busy_done", bus.busy, 32'd1);
      check("st_status_done", bus.status_word, exp_status(1'b1, 1'b0, 1'b1));
      n_ramps++; r_exp_cnt++;
      tick(1);
      check("st_done_w", bus.done, 32'd0);
      check("st_busy_fall", bus.busy, 32'd0);
      check("st_status_end", bus.status_word, exp_status(1'b0, 1'b0, 1'b1));

      // zero-step jump
      set_tgt(16'h0000, 16'hFFFF);
      bus.ctrl_word = mk_ctrl(16'd0, 8'd0, 1'b0, 1'b1);
      tick(1);
      check("jmp_busy", bus.busy, 32'd1);
      bus.ctrl_word = 32'd0;
      tick(1);
      check("jmp_done", bus.done, 32'd1);
      check("jmp_i", bus.i_scale, 32'h0000);
      check("jmp_q", bus.q_scale, 32'hFFFF);
      n_ramps++; r_exp_cnt++;
      tick(1);
      check("jmp_busy_fall", bus.busy, 32'd0);

      // large step, distance 10: clamps in one STEP
      set_tgt(16'h000A, 16'hFFF5);
      bus.ctrl_word = mk_ctrl(16'd0, 8'd255, 1'b0, 1'b1);
      tick(1);
      bus.ctrl_word = 32'd0;
      tick(1);
      check("clamp_done", bus.done, 32'd1);
      check("clamp_i", bus.i_scale, 32'h000A);
      check("clamp_q", bus.q_scale, 32'hFFF5);
      n_ramps++; r_exp_cnt++;
      tick(1);

      // large step over two increments, clamp on the second
      set_tgt(16'h0200, 16'hFFF5);
      bus.ctrl_word = mk_ctrl(16'd0, 8'd255, 1'b0, 1'b1);
      tick(1);
      bus.ctrl_word = 32'd0;
      tick(1);
      check("clamp2_i1", bus.i_scale, 32'h0109);
      check("clamp2_nodone", bus.done, 32'd0);
      tick(2);
      check("clamp2_i2", bus.i_scale, 32'h0200);
      check("clamp2_q2", bus.q_scale, 32'hFFF5);
      check("clamp2_done", bus.done, 32'd1);
      n_ramps++; r_exp_cnt++;
      tick(1);

      // abort after the second increment
      set_tgt(16'h0300, 16'hFFD5);
      bus.ctrl_word = mk_ctrl(16'd3, 8'd16, 1'b0, 1'b1);
      tick(1);
      bus.ctrl_word = mk_ctrl(16'd3, 8'd16, 1'b0, 1'b0);
      tick(1);
      check("ab_i1", bus.i_scale, 32'h0210);
      check("ab_q1", bus.q_scale, 32'hFFE5);
      tick(4);
      check("ab_i2", bus.i_scale, 32'h0220);
      check("ab_q2", bus.q_scale, 32'hFFD5);
      bus.ctrl_word = mk_ctrl(16'd3, 8'd16, 1'b1, 1'b0);
      tick(1);
      check("ab_busy", bus.busy, 32'd0);
      n_done_seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus.done === 1'b1) n_done_seen++;
         tick(1);
      end
      check("ab_no_done", n_done_seen, 32'd0);
      bus.ctrl_word = 32'd0;
      tick(1);
      check("ab_i_hold", bus.i_scale, 32'h0220);
      check("ab_q_hold", bus.q_scale, 32'hFFD5);
      check("ab_status", bus.status_word, exp_status(1'b0, 1'b0, 1'b0));

      // abort beats a simultaneous go; go held after abort is not a new edge
      bus.ctrl_word = mk_ctrl(16'd0, 8'd0, 1'b1, 1'b1);
      tick(1);
      check("abgo_busy", bus.busy, 32'd0);
      bus.ctrl_word = mk_ctrl(16'd0, 8'd0, 1'b0, 1'b1);
      tick(1);
      check("abgo_busy2", bus.busy, 32'd0);
      bus.ctrl_word = 32'd0;
      tick(1);
      check("abgo_i", bus.i_scale, 32'h0220);

      // overrun: second go during busy
      set_tgt(16'h0230, 16'hFFD5);
      bus.ctrl_word = mk_ctrl(16'd1, 8'd8, 1'b0, 1'b1);
      tick(1);
      bus.ctrl_word = mk_ctrl(16'd1, 8'd8, 1'b0, 1'b0);
      tick(1);
      check("ov_i1", bus.i_scale, 32'h0228);
      bus.ctrl_word = mk_ctrl(16'd1, 8'd8, 1'b0, 1'b1);
      tick(1);
      check("ov_status_set", bus.status_word, exp_status(1'b1, 1'b1, 1'b0));
      tick(1);
      check("ov_done", bus.done, 32'd1);
      check("ov_i2", bus.i_scale, 32'h0230);
      n_ramps++; r_exp_cnt++;
      bus.ctrl_word = mk_ctrl(16'd1, 8'd8, 1'b0, 1'b0);
      tick(1);
      check("ov_status_sticky", bus.status_word, exp_status(1'b0, 1'b1, 1'b1));
      bus.ctrl_word = mk_ctrl(16'd1, 8'd8, 1'b0, 1'b1);
      tick(1);
      check("ov_status_clr", bus.status_word, exp_status(1'b1, 1'b0, 1'b1));
      bus.ctrl_word = 32'd0;
      tick(1);
      check("ov_done2", bus.done, 32'd1);
      n_ramps++; r_exp_cnt++;
      tick(1);
      check("ov_status_end", bus.status_word, exp_status(1'b0, 1'b0, 1'b1));

      // counter wrap after 256 completed ramps
      set_tgt(16'h1111, 16'h2222);
      while (n_ramps < 255) do_jump();
      check("cnt_255", bus.status_word, exp_status(1'b0, 1'b0, 1'b1));
      do_jump();
      check("cnt_wrap", {24'd0, bus.status_word[31:24]}, {24'd0, exp_status(1'b0, 1'b0, 1'b1) >> 24});
      check("cnt_wrap_status", bus.status_word, exp_status(1'b0, 1'b0, 1'b1));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adc_scale_ramp_ctrl.md
Name: adc_scale_ramp_ctrl

Overview:
- Sequencer that drives the ADC I/Q scale factors applied in the DAC/ADC datapath.
- Inputs are three software registers: I target word, Q target word and control word.
- Targets are reached in software-configured increments, with a configurable dwell between increments, so scale changes never step abruptly.
- Exports a status word for a readback register.

Parameters:
- W, 16, scale width in bits (2 ≤ W ≤ 16); register bits [W-1:0] are used.
- RESET_SCALE, 16'h4000, value of i_scale/q_scale after reset (lower W bits used).

Ports:
- user_clk  in  1  sole clock.
- user_rst_n  in  1  asynchronous active-low reset.
- i_target_word  in  32  I target; bits [W-1:0] used.
- q_target_word  in  32  Q target; bits [W-1:0] used.
- ctrl_word  in  32  control word:
  - bit0 go (rising-edge triggered)
  - bit1 abort (level)
  - [15:8] step
  - [31:16] dwell cycles
- i_scale  out  W  applied I scale.
- q_scale  out  W  applied Q scale.
- busy  out  1  high while a ramp is in progress.
- done  out  1  one-cycle pulse when a ramp completes.
- status_word  out  32  readback:
  - bit0 busy
  - bit1 overrun
  - bit2 at_target
  - [31:24] ramp count (see Optional Feature)
  - all other bits 0.

Behaviour:
- Clock and reset:
  - Single clock; reset asynchronous, active-low; all flops cleared on assertion.
  - Reset values: i_scale = q_scale = RESET_SCALE[W-1:0]; busy = 0; done = 0; overrun = 0; latched targets = RESET_SCALE (so at_target = 1); status_word = 32'h0000_0004.
- go edge detection: ctrl_word[0] is registered; a go event is cur=1 and prev=1'b0. The prev flop resets to 1, so a go held high through reset does not trigger.
- FSM states: IDLE, STEP, DWELL, DONE.
- IDLE:
  - On a go event with abort=0: latch i_tgt, q_tgt, step and dwell, then go to STEP.
  - busy rises the cycle after the go edge is seen.
- STEP (one cycle): per channel, using W+1-bit arithmetic with no wrap:
  - cur < tgt: cur = min(cur + step, tgt).
  - cur > tgt: cur = max(cur − step, tgt).
  - equal: hold.
  - step = 0 loads tgt directly (jump).
  - Next state is DONE if both channels equal their targets after this update; otherwise DWELL.
- DWELL:
  - Counts dwell cycles, then returns to STEP.
  - dwell = 0 returns to STEP on the next cycle (minimum 2 cycles per increment).
- DONE (one cycle): done = 1; ramp counter increments; next state IDLE; busy = 0 from the next cycle.
- Outputs i_scale/q_scale are registered: a value updated in STEP is visible the following cycle. Zero-step ramps finish in 3 cycles: edge→STEP→DONE.
- Abort: ctrl_word[1] = 1 in any state forces IDLE next cycle.
  - Scales hold their current values; no done pulse; counter unchanged.
  - Abort has priority over a go event in the same cycle.
- Overrun: a go event while busy is ignored and sets the sticky overrun bit. overrun clears at the next accepted go (in IDLE) or at reset.
- Target changes: edits to the target words mid-ramp have no effect until the next accepted go; targets are latched.
- at_target = (i_scale == i_tgt) && (q_scale == q_tgt), using the latched targets.

Optional Feature:
- Macro: ADC_SCALE_RAMP_CNT_EN.
- Defined: 8-bit completed-ramp counter, reset 0, +1 per DONE state, wraps 255→0, reported on status_word[31:24].
- Undefined: no counter flops; status_word[31:24] is tied to 0.

Test Plan:
- Reset: deassert user_rst_n → i_scale = q_scale = 16'h4000, busy = 0, status_word = 32'h0000_0004.
- Stepped ramp: i_tgt = 16'h4010, q_tgt = 16'h3FF8, step = 4, dwell = 2, go 0→1.
  - I steps 4004, 4008, 400C, 4010; Q steps 3FFC, 3FF8, then holds.
  - DONE after the 4th STEP; updates spaced 3 cycles apart.
  - done pulse width 1 cycle; busy drops the cycle after done.
- Jump and clamp:
  - step = 0, targets 16'h0000/16'hFFFF → reached in one STEP; done 2 cycles after the edge is registered.
  - step = 255 with remaining distance 10 → clamps exactly at target, no overshoot.
- Abort mid-ramp: assert abort after the 2nd increment → state IDLE, scales frozen at the 2nd-step values, no done pulse, counter unchanged.
- Overrun: second go edge during busy → ignored, status bit1 = 1, ramp completes normally; next idle go clears bit1.
- Counter and reset-with-go: with ADC_SCALE_RAMP_CNT_EN, 256 ramps → status[31:24] wraps to 0. Holding go = 1 through reset produces no ramp.
